pc_gen: RTL and testbench

Parametrised next-PC generator for the fetch front end, holding the pre-fetch PC register. Successor to the combinational next-PC and flush logic. It chooses among sequential, branch, jump, jump-register, exception and ERET targets and generates the pipeline flush vector. Unlike its predecessor it:
- supports multi-instruction fetch;
- holds a control-flow redirect that arrives during a stall instead of losing it;
- optionally predicts returns from a return-address stack (RAS).

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_gen_ras.sv | 73 +++++++
 rtl/pc_gen.sv | 154 +++++++++++++++
 tb/tb_pc_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// =============================================================================
// pc_gen_pkg : npc_op encodings and default vectors shared by pc_gen blocks
// Rev 1.0
// =============================================================================
package pc_gen_pkg;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [31:0] DEF_RESET_VEC = 32'hBFC0_0000;
   localparam logic [31:0] DEF_EX_VEC    = 32'hBFC0_0380;

endpackage
`default_nettype wire

// File: rtl/pc_gen_ras.sv
`default_nettype none
// =============================================================================
// pc_gen_ras : circular return-address stack; a push when full overwrites the oldest
// Rev 1.0
// =============================================================================
module pc_gen_ras
   import pc_gen_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [AW-1:0]                push_val_i,
   output logic [AW-1:0]                top_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [AW-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] top_idx, next_idx, wr_idx;
   logic             wr_en;

   // ptr_q names the next free slot; the top lives one slot behind it
   assign top_idx  = (ptr_q == '0) ? PTR_W'(DEPTH-1) : ptr_q - PTR_W'(1);
   assign next_idx = (ptr_q == PTR_W'(DEPTH-1)) ? '0 : ptr_q + PTR_W'(1);
   assign top_o    = mem_q[top_idx];
   assign count_o  = cnt_q;

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = ptr_q;
      if (push_i && pop_i) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (push_i) begin
         wr_en  = 1'b1;
         ptr_d  = next_idx;
         if (cnt_q != CNT_W'(DEPTH)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pop_i && (cnt_q != '0)) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= push_val_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// =============================================================================
// pc_gen : next-PC generator and pre-fetch PC register; RAS enabled by PC_GEN_RAS_EN
// Rev 1.0
// =============================================================================
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                FETCH_W   = 1,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
   parameter logic [ADDR_W-1:0] EX_VEC    = ADDR_W'(DEF_EX_VEC),
   parameter int                RAS_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             pc_wr,
   input  logic [1:0]                       npc_op,
   input  logic [ADDR_W-1:0]                if_pc,
   input  logic [25:0]                      imm,
   input  logic [ADDR_W-1:0]                ret_addr,
   input  logic                             link,
   input  logic                             is_ret,
   input  logic                             mem_eret_flush,
   input  logic                             mem_ex,
   input  logic [ADDR_W-1:0]                epc,
   output logic [ADDR_W-1:0]                pf_pc,
   output logic [ADDR_W-1:0]                npc,
   output logic                             pf_flush,
   output logic                             if_flush,
   output logic                             id_flush,
   output logic                             ex_flush,
   output logic                             mem1_flush,
   output logic                             redirect_pending,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

   localparam int                CNT_W    = $clog2(RAS_DEPTH+1);
   localparam logic [ADDR_W-1:0] SEQ_STEP = ADDR_W'(4*FETCH_W);

   logic [ADDR_W-1:0] pf_pc_q, pf_pc_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              pend_q, pend_d;
   logic              commit, op_redirect;
   logic [ADDR_W-1:0] seq_tgt, br_tgt, j_tgt, cf_tgt;
   logic              ras_pop;
   logic [ADDR_W-1:0] ras_top;

   assign seq_tgt = pf_pc_q + SEQ_STEP;
   assign br_tgt  = if_pc + {{(ADDR_W-18){imm[15]}}, imm[15:0], 2'b00};

   generate
      if (ADDR_W > 28) begin : g_jtgt_region
         assign j_tgt = {if_pc[ADDR_W-1:28], imm, 2'b00};
      end else begin : g_jtgt_flat
         assign j_tgt = {imm, 2'b00};
      end
   endgenerate

   assign commit      = mem_eret_flush | mem_ex;
   // A held redirect masks npc_op: the stalled stage is replaying the same instruction
   assign op_redirect = (npc_op != NPC_SEQ) && !pend_q;

   always_comb begin
      cf_tgt = seq_tgt;
      case (npc_op)
         NPC_BR:  cf_tgt = br_tgt;
         NPC_J:   cf_tgt = j_tgt;
         NPC_JR:  cf_tgt = ras_pop ? ras_top : ret_addr;
         default: cf_tgt = seq_tgt;
      endcase
   end

   always_comb begin
      npc = seq_tgt;
      if (mem_eret_flush) begin
         npc = epc;
      end else if (mem_ex) begin
         npc = EX_VEC;
      end else if (pend_q) begin
         npc = pend_tgt_q;
      end else if (op_redirect) begin
         npc = cf_tgt;
      end
   end

   always_comb begin
      pf_pc_d    = pf_pc_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      if (commit || pc_wr) begin
         pf_pc_d = npc;
      end
      if (commit || pc_wr) begin
         pend_d = 1'b0;
      end else if (op_redirect) begin
         pend_d     = 1'b1;
         pend_tgt_d = cf_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pf_pc_q    <= RESET_VEC;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         pf_pc_q    <= pf_pc_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   assign pf_pc            = pf_pc_q;
   assign redirect_pending = pend_q;
   assign if_flush         = commit & ~rst;
   assign id_flush         = commit & ~rst;
   assign ex_flush         = commit & ~rst;
   assign mem1_flush       = commit & ~rst;
   assign pf_flush         = (commit | (pc_wr & (pend_q | (npc_op != NPC_SEQ)))) & ~rst;

`ifdef PC_GEN_RAS_EN
   logic             ras_accept, ras_push;
   logic [CNT_W-1:0] ras_cnt;

   // A jump is accepted when it is applied now or captured into the pending slot
   assign ras_accept = !commit && !pend_q && ((npc_op == NPC_J) || (npc_op == NPC_JR));
   assign ras_push   = ras_accept && link;
   assign ras_pop    = ras_accept && (npc_op == NPC_JR) && is_ret && (ras_cnt != '0);

   pc_gen_ras #(
      .DEPTH (RAS_DEPTH),
      .AW    (ADDR_W)
   ) u_ras (
      .clk        (clk),
      .rst        (rst),
      .push_i     (ras_push),
      .pop_i      (ras_pop),
      .push_val_i (if_pc + ADDR_W'(8)),
      .top_o      (ras_top),
      .count_o    (ras_cnt)
   );

   assign ras_count = ras_cnt;
`else
   logic unused_ras;
   assign unused_ras = link ^ is_ret;
   assign ras_pop    = 1'b0;
   assign ras_top    = '0;
   assign ras_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// =============================================================================
// tb_pc_gen : directed self-checking bench for pc_gen (FETCH_W=2, RAS_DEPTH=2)
// Rev 1.0
// =============================================================================
module tb_pc_gen;
   import pc_gen_pkg::*;

   logic        clk, rst, pc_wr, link, is_ret, mem_eret_flush, mem_ex;
   logic [1:0]  npc_op;
   logic [31:0] if_pc, ret_addr, epc, pf_pc, npc;
   logic [25:0] imm;
   logic        pf_flush, if_flush, id_flush, ex_flush, mem1_flush, redirect_pending;
   logic [1:0]  ras_count;

   int checks   = 0;
   int failures = 0;

   pc_gen #(.ADDR_W(32), .FETCH_W(2), .RAS_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .pc_wr(pc_wr), .npc_op(npc_op), .if_pc(if_pc), .imm(imm),
      .ret_addr(ret_addr), .link(link), .is_ret(is_ret), .mem_eret_flush(mem_eret_flush),
      .mem_ex(mem_ex), .epc(epc), .pf_pc(pf_pc), .npc(npc), .pf_flush(pf_flush),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem1_flush(mem1_flush),
      .redirect_pending(redirect_pending), .ras_count(ras_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle;
      pc_wr = 1'b0; npc_op = NPC_SEQ; if_pc = '0; imm = '0; ret_addr = '0;
      link = 1'b0; is_ret = 1'b0; mem_eret_flush = 1'b0; mem_ex = 1'b0; epc = '0;
   endtask

   task automatic test_reset;
      set_idle();
      rst = 1'b1; pc_wr = 1'b1; mem_ex = 1'b1; npc_op = NPC_J;
      #1;
      checks++; if ({pf_flush, if_flush, id_flush, ex_flush, mem1_flush} !== 5'b0) begin failures++; $display("FAIL reset_flush actual=%b required=00000", {pf_flush, if_flush, id_flush, ex_flush, mem1_flush}); end
      tick();
      tick();
      checks++; if (pf_pc !== 32'hBFC00000) begin failures++; $display("FAIL reset_pf_pc actual=%h required=bfc00000", pf_pc); end
      checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL reset_pending actual=%b required=0", redirect_pending); end
      checks++; if (ras_count !== 2'd0) begin failures++; $display("FAIL reset_ras_count actual=%0d required=0", ras_count); end
      set_idle();
      rst = 1'b0;
   endtask

   task automatic test_seq;
      pc_wr = 1'b1;
      #1;
      checks++; if (pf_pc !== 32'hBFC00000) begin failures++; $display("FAIL seq_pf_pc0 actual=%h required=bfc00000", pf_pc); end
      checks++; if (npc !== 32'hBFC00008) begin failures++; $display("FAIL seq_npc actual=%h required=bfc00008", npc); end
      checks++; if ({pf_flush, if_flush, id_flush, ex_flush, mem1_flush} !== 5'b0) begin failures++; $display("FAIL seq_flush actual=%b required=00000", {pf_flush, if_flush, id_flush, ex_flush, mem1_flush}); end
      tick();
      checks++; if (pf_pc !== 32'hBFC00008) begin failures++; $display("FAIL seq_pf_pc1 actual=%h required=bfc00008", pf_pc); end
      tick();
      checks++; if (pf_pc !== 32'hBFC00010) begin failures++; $display("FAIL seq_pf_pc2 actual=%h required=bfc00010", pf_pc); end
   endtask

   task automatic test_branch;
      pc_wr = 1'b1; npc_op = NPC_BR; if_pc = 32'h0000_1000; imm = 26'h000FFFE;
      #1;
      checks++; if (npc !== 32'h0000_0FF8) begin failures++; $display("FAIL branch_npc actual=%h required=00000ff8", npc); end
      checks++; if (pf_flush !== 1'b1) begin failures++; $display("FAIL branch_pf_flush actual=%b required=1", pf_flush); end
      checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL branch_if_flush actual=%b required=0", if_flush); end
      tick();
      checks++; if (pf_pc !== 32'h0000_0FF8) begin failures++; $display("FAIL branch_pf_pc actual=%h required=00000ff8", pf_pc); end
      set_idle();
   endtask

   task automatic test_stall_redirect;
      pc_wr = 1'b0; npc_op = NPC_J; if_pc = 32'h2000_0040; imm = 26'h0012345;
      #1;
      checks++; if (pf_flush !== 1'b0) begin failures++; $display("FAIL stall_pf_flush_pre actual=%b required=0", pf_flush); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL stall_pending_%0d actual=%b required=1", i, redirect_pending); end
         checks++; if (pf_pc !== 32'h0000_0FF8) begin failures++; $display("FAIL stall_pf_pc_%0d actual=%h required=00000ff8", i, pf_pc); end
         checks++; if (pf_flush !== 1'b0) begin failures++; $display("FAIL stall_pf_flush_%0d actual=%b required=0", i, pf_flush); end
      end
      pc_wr = 1'b1; npc_op = NPC_SEQ;
      #1;
      checks++; if (pf_flush !== 1'b1) begin failures++; $display("FAIL release_pf_flush actual=%b required=1", pf_flush); end
      checks++; if (npc !== 32'h2004_8D14) begin failures++; $display("FAIL release_npc actual=%h required=20048d14", npc); end
      tick();
      checks++; if (pf_pc !== 32'h2004_8D14) begin failures++; $display("FAIL release_pf_pc actual=%h required=20048d14", pf_pc); end
      checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL release_pending actual=%b required=0", redirect_pending); end
      checks++; if (pf_flush !== 1'b0) begin failures++; $display("FAIL release_single_pulse actual=%b required=0", pf_flush); end
      tick();
      checks++; if (pf_pc !== 32'h2004_8D1C) begin failures++; $display("FAIL release_seq actual=%h required=20048d1c", pf_pc); end
      set_idle();
   endtask

   task automatic test_commit;
      pc_wr = 1'b0; npc_op = NPC_BR; if_pc = 32'h0000_1000; imm = 26'h4;
      tick();
      checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL commit_pre_pending actual=%b required=1", redirect_pending); end
      mem_ex = 1'b1; mem_eret_flush = 1'b1; epc = 32'h8000_1234;
      #1;
      checks++; if (npc !== 32'h8000_1234) begin failures++; $display("FAIL commit_eret_npc actual=%h required=80001234", npc); end
      checks++; if ({pf_flush, if_flush, id_flush, ex_flush, mem1_flush} !== 5'b11111) begin failures++; $display("FAIL commit_flushes actual=%b required=11111", {pf_flush, if_flush, id_flush, ex_flush, mem1_flush}); end
      tick();
      checks++; if (pf_pc !== 32'h8000_1234) begin failures++; $display("FAIL commit_eret_pf_pc actual=%h required=80001234", pf_pc); end
      checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL commit_pending_clr actual=%b required=0", redirect_pending); end
      mem_eret_flush = 1'b0; npc_op = NPC_J;
      #1;
      checks++; if (npc !== 32'hBFC0_0380) begin failures++; $display("FAIL commit_ex_npc actual=%h required=bfc00380", npc); end
      tick();
      checks++; if (pf_pc !== 32'hBFC0_0380) begin failures++; $display("FAIL commit_ex_pf_pc actual=%h required=bfc00380", pf_pc); end
      checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL commit_no_capture actual=%b required=0", redirect_pending); end
      set_idle();
   endtask

   task automatic test_reset_midop;
      pc_wr = 1'b0; npc_op = NPC_BR; if_pc = 32'h0000_1000; imm = 26'h10;
      tick();
      checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL midrst_pre_pending actual=%b required=1", redirect_pending); end
      rst = 1'b1; pc_wr = 1'b1; npc_op = NPC_SEQ;
      tick();
      checks++; if (pf_pc !== 32'hBFC00000) begin failures++; $display("FAIL midrst_pf_pc actual=%h required=bfc00000", pf_pc); end
      checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL midrst_pending actual=%b required=0", redirect_pending); end
      rst = 1'b0;
      set_idle();
   endtask

   task automatic test_jr_plain;
      pc_wr = 1'b1; npc_op = NPC_JR; is_ret = 1'b1; ret_addr = 32'h1234_5678; if_pc = 32'h0000_0600;
      #1;
      checks++; if (npc !== 32'h1234_5678) begin failures++; $display("FAIL jr_npc actual=%h required=12345678", npc); end
      tick();
      checks++; if (pf_pc !== 32'h1234_5678) begin failures++; $display("FAIL jr_pf_pc actual=%h required=12345678", pf_pc); end
      checks++; if (ras_count !== 2'd0) begin failures++; $display("FAIL jr_ras_count actual=%0d required=0", ras_count); end
      set_idle();
   endtask

`ifdef PC_GEN_RAS_EN
   task automatic test_ras_overflow;
      logic [31:0] call_pc [3];
      logic [1:0]  cnt_exp [3];
      logic [31:0] ret_exp [3];
      logic [1:0]  pop_cnt [3];
      call_pc = '{32'h100, 32'h200, 32'h300};
      cnt_exp = '{2'd1, 2'd2, 2'd2};
      ret_exp = '{32'h308, 32'h208, 32'hDEAD0000};
      pop_cnt = '{2'd1, 2'd0, 2'd0};
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pc_wr = 1'b1; npc_op = NPC_J; link = 1'b1; is_ret = 1'b0; if_pc = call_pc[i]; imm = 26'h40;
         tick();
         checks++; if (ras_count !== cnt_exp[i]) begin failures++; $display("FAIL ras_push_cnt_%0d actual=%0d required=%0d", i, ras_count, cnt_exp[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         pc_wr = 1'b1; npc_op = NPC_JR; link = 1'b0; is_ret = 1'b1; if_pc = 32'h500; ret_addr = 32'hDEAD0000;
         #1;
         checks++; if (npc !== ret_exp[i]) begin failures++; $display("FAIL ras_ret_npc_%0d actual=%h required=%h", i, npc, ret_exp[i]); end
         tick();
         checks++; if (ras_count !== pop_cnt[i]) begin failures++; $display("FAIL ras_pop_cnt_%0d actual=%0d required=%0d", i, ras_count, pop_cnt[i]); end
      end
      set_idle();
   endtask

   task automatic test_ras_push_pop;
      rst = 1'b1; tick(); rst = 1'b0;
      pc_wr = 1'b1; npc_op = NPC_J; link = 1'b1; if_pc = 32'h100; imm = 26'h40;
      tick();
      npc_op = NPC_JR; link = 1'b1; is_ret = 1'b1; if_pc = 32'h400; ret_addr = 32'hDEAD0000;
      #1;
      checks++; if (npc !== 32'h108) begin failures++; $display("FAIL ras_pp_npc actual=%h required=00000108", npc); end
      tick();
      checks++; if (ras_count !== 2'd1) begin failures++; $display("FAIL ras_pp_cnt actual=%0d required=1", ras_count); end
      link = 1'b0;
      #1;
      checks++; if (npc !== 32'h408) begin failures++; $display("FAIL ras_pp_newtop actual=%h required=00000408", npc); end
      tick();
      checks++; if (ras_count !== 2'd0) begin failures++; $display("FAIL ras_pp_final_cnt actual=%0d required=0", ras_count); end
      set_idle();
   endtask
`endif

   initial begin
      set_idle();
      rst = 1'b1;
      test_reset();
      test_seq();
      test_branch();
      test_stall_redirect();
      test_commit();
      test_reset_midop();
      test_jr_plain();
`ifdef PC_GEN_RAS_EN
      test_ras_overflow();
      test_ras_push_pop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
